dmem_responder: RTL and testbench

Data-memory responder for the MIPS core: the memory-side end of the processor's load/store interface. It accepts one load or store request at a time over a req/ack handshake, services it after a programmable number of wait states, and returns read data with an error flag. It sits between the datapath's ALU-result/store-data path and the word-addressed data RAM, replacing direct combinational RAM access with a timed, handshaked access.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// +---------------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the data-memory responder       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +---------------------------------------------------------------------------+
// | dmem_array : single-port synchronous RAM, registered write and read       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [WORD_W-1:0]              wdata_i,
  output logic [WORD_W-1:0]              rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +---------------------------------------------------------------------------+
// | dmem_responder : req/ack load-store responder with programmable waits    |
// | Option: DMEM_ALIGN_CHECK_EN flags addr[1:0]!=0 as an access error.        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              DM_req,
  input  logic              DM_we,
  input  logic [WORD_W-1:0] DM_addr,
  input  logic [WORD_W-1:0] DM_wdata,
  output logic              DM_ack,
  output logic [WORD_W-1:0] DM_rdata,
  output logic              DM_err,
  output logic              DM_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              commit;
  logic              range_err;
  logic              align_err;
  logic              access_err;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] rdata_out;

  assign range_err = |addr_q[WORD_W-1:AW+2];
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = |addr_q[1:0];
`else
  logic unused_addr_lsb;
  assign align_err       = 1'b0;
  assign unused_addr_lsb = ^addr_q[1:0];
`endif
  assign access_err = range_err | align_err;

  // The RAM is touched only on the commit edge; a reset on that edge aborts it.
  assign commit = (state_q == ST_WAIT) && (cnt_q == '0) && !SYS_reset;
  assign ram_we = commit && we_q && !access_err;
  assign ram_re = commit && !we_q && !access_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (SYS_clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // In RESP the fresh result is shown; it is then latched and held until the next ack.
  always_comb begin
    rdata_out = rdata_q;
    if (state_q == ST_RESP) begin
      if (err_q) begin
        rdata_out = '0;
      end else if (!we_q) begin
        rdata_out = ram_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (DM_req) begin
          we_d    = DM_we;
          addr_d  = DM_addr;
          wdata_d = DM_wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d   = 1'b1;
          err_d   = access_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rdata_d = rdata_out;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign DM_ack   = ack_q;
  assign DM_err   = err_q;
  assign DM_rdata = rdata_out;
  assign DM_busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +---------------------------------------------------------------------------+
// | tb_dmem_responder : self-checking bench for dmem_responder                |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

  localparam int WAITC = 2;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0 = 1'b0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAITC)) dut (
    .SYS_clk(clk), .SYS_reset(reset), .DM_req(req), .DM_we(we),
    .DM_addr(addr), .DM_wdata(wdata), .DM_ack(ack), .DM_rdata(rdata),
    .DM_err(err), .DM_busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .SYS_clk(clk), .SYS_reset(reset), .DM_req(req0), .DM_we(1'b1),
    .DM_addr(32'h40), .DM_wdata(32'hA5A5_0F0F), .DM_ack(ack0), .DM_rdata(rdata0),
    .DM_err(err0), .DM_busy(busy0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v);
    exp_t e;
    int   n;
    exp_q.push_back('{v.name, v.exp_err, v.exp_rdata});
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    check({v.name, " busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    e = exp_q.pop_front();
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ack after %0d cycles, expected ack", e.name, n);
    end else begin
      check({e.name, " latency"}, 32'(n), 32'(WAITC + 1));
      check({e.name, " err"}, {31'b0, err}, {31'b0, e.err});
      check({e.name, " rdata"}, rdata, e.rdata);
    end
    @(posedge clk); #1;
    check({e.name, " idle ack/busy"}, {30'b0, ack, busy}, 32'd0);
    check({e.name, " held rdata"}, rdata, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int last;
    int bad_gap;
    int errsum;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, "st_10"};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "ld_10"};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, "st_00"};
    vecs[3]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000, "ld_oor"};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 1'b1, 32'h0000_0000, "st_oor"};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111, "ld_00"};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[6]  = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, "st_mis13"};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "ld_10b"};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 1'b0, 32'hDEAD_BEEF, "st_3fc"};
`else
    vecs[6]  = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b0, 32'h1111_1111, "st_mis13"};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hCAFE_F00D, "ld_10b"};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 1'b0, 32'hCAFE_F00D, "st_3fc"};
`endif
    vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_CAFE, "ld_3fc"};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h55AA_55AA, 1'b0, 32'h0BAD_CAFE, "st_20"};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, "ld_top"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset idle outputs", {rdata[29:0], ack, err} | {31'b0, busy}, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i]);
    end

    // Load with req pulses during WAIT: exactly one ack expected.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    req = 1'b0;
    acks = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ack) acks++;
      req = (i == 0 || i == 2) ? 1'b1 : 1'b0;
    end
    check("pulse_in_wait ack count", 32'(acks), 32'd1);
    check("pulse_in_wait busy", {31'b0, busy}, 32'd0);

    // Reset in the first WAIT cycle of a store aborts it.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    reset = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort outputs", {rdata[29:0], ack, err} | {31'b0, busy}, 32'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("abort no ack", 32'(acks), 32'd0);
    do_req('{1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h55AA_55AA, "ld_20_after_abort"});

    // Held request, zero wait states: one ack every 3 cycles.
    @(negedge clk);
    req0 = 1'b1;
    acks = 0; last = -1; bad_gap = 0; errsum = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ack0) begin
        if (last >= 0 && (i - last) != 3) bad_gap++;
        if (err0) errsum++;
        last = i;
        acks++;
      end
    end
    req0 = 1'b0;
    check("held_req ack count", 32'(acks), 32'd10);
    check("held_req bad gaps", 32'(bad_gap), 32'd0);
    check("held_req err", 32'(errsum), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
